// File: rtl/uart_tx_sequencer.sv
// uart_tx_sequencer
//
// Serialises parallel words onto a UART line. It gates an external baud
// generator through baud_enable and advances one bit period on each clk_baud
// tick. A frame is a start bit, DATA_BITS data bits sent LSB first, an optional
// parity bit and STOP_BITS stop bits. One further word can be buffered while a
// frame is in flight, so consecutive frames go out with no idle gap.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   in_data      word to transmit
//   in_valid     in_data is valid
//   in_ready     holding register empty; transfer when in_valid && in_ready
//   clk_baud     one-cycle bit tick from the baud generator
//   baud_enable  runs the baud generator (low parks it one count before a tick)
//   tx           serial line, idle high
//   busy         sequencer is not idle
//   frame_done   one-cycle pulse on the edge that ends the last stop bit

module uart_tx_sequencer #(
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 clk_baud,
    output logic                 baud_enable,
    output logic                 tx,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int                CNT_W      = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0]  DATA_LAST  = CNT_W'(DATA_BITS);
    localparam logic [1:0]        STOP_LAST  = 2'(STOP_BITS);
    localparam bit                HAS_PARITY = (PARITY_MODE != 0);

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                 state_reg, state_next;
    logic [DATA_BITS-1:0]   shift_reg, shift_next;
    logic [DATA_BITS-1:0]   hold_reg, hold_next;
    logic                   hold_full_reg, hold_full_next;
    logic                   parity_reg, parity_next;
    logic [CNT_W-1:0]       bit_cnt_reg, bit_cnt_next;
    logic [1:0]             stop_cnt_reg, stop_cnt_next;
    logic                   tx_reg, tx_next;
    logic                   baud_enable_reg, baud_enable_next;
    logic                   frame_done_reg, frame_done_next;
    logic                   accept;

    // Parity is taken from the whole word when it is loaded into the shift
    // register, because the shift register is consumed bit by bit afterwards.
    function automatic logic frame_parity(input logic [DATA_BITS-1:0] word);
        frame_parity = (PARITY_MODE == 2) ? ~(^word) : (^word);
    endfunction

    assign accept      = in_valid && !hold_full_reg;
    assign in_ready    = !hold_full_reg;
    assign busy        = (state_reg != IDLE);
    assign tx          = tx_reg;
    assign baud_enable = baud_enable_reg;
    assign frame_done  = frame_done_reg;

    always_comb begin
        state_next       = state_reg;
        shift_next       = shift_reg;
        hold_next        = hold_reg;
        hold_full_next   = hold_full_reg;
        parity_next      = parity_reg;
        bit_cnt_next     = bit_cnt_reg;
        stop_cnt_next    = stop_cnt_reg;
        tx_next          = tx_reg;
        baud_enable_next = baud_enable_reg;
        frame_done_next  = 1'b0;

        // Words arriving in IDLE skip the holding register entirely.
        if (accept) begin
            if (state_reg == IDLE) begin
                shift_next       = in_data;
                parity_next      = frame_parity(in_data);
                baud_enable_next = 1'b1;
                state_next       = ARM;
            end else begin
                hold_next      = in_data;
                hold_full_next = 1'b1;
            end
        end

        if (clk_baud) begin
            case (state_reg)
                ARM: begin
                    tx_next    = 1'b0;
                    state_next = START;
                end
                START: begin
                    tx_next      = shift_reg[0];
                    shift_next   = shift_reg >> 1;
                    bit_cnt_next = CNT_W'(1);
                    state_next   = DATA;
                end
                DATA: begin
                    if (bit_cnt_reg < DATA_LAST) begin
                        tx_next      = shift_reg[0];
                        shift_next   = shift_reg >> 1;
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end else if (HAS_PARITY) begin
                        tx_next    = parity_reg;
                        state_next = PARITY;
                    end else begin
                        tx_next       = 1'b1;
                        stop_cnt_next = 2'd1;
                        state_next    = STOP;
                    end
                end
                PARITY: begin
                    tx_next       = 1'b1;
                    stop_cnt_next = 2'd1;
                    state_next    = STOP;
                end
                STOP: begin
                    if (stop_cnt_reg < STOP_LAST) begin
                        stop_cnt_next = stop_cnt_reg + 1'b1;
                    end else begin
                        frame_done_next = 1'b1;
                        bit_cnt_next    = '0;
                        stop_cnt_next   = '0;
                        if (hold_full_reg) begin
                            shift_next     = hold_reg;
                            parity_next    = frame_parity(hold_reg);
                            hold_full_next = 1'b0;
                            tx_next        = 1'b0;
                            state_next     = START;
                        end else if (accept) begin
                            // A word arriving on the final stop tick goes
                            // straight out; undo the hold load made above.
                            shift_next     = in_data;
                            parity_next    = frame_parity(in_data);
                            hold_full_next = 1'b0;
                            tx_next        = 1'b0;
                            state_next     = START;
                        end else begin
                            baud_enable_next = 1'b0;
                            state_next       = IDLE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            shift_reg       <= '0;
            hold_reg        <= '0;
            hold_full_reg   <= 1'b0;
            parity_reg      <= 1'b0;
            bit_cnt_reg     <= '0;
            stop_cnt_reg    <= '0;
            tx_reg          <= 1'b1;
            baud_enable_reg <= 1'b0;
            frame_done_reg  <= 1'b0;
        end else begin
            state_reg       <= state_next;
            shift_reg       <= shift_next;
            hold_reg        <= hold_next;
            hold_full_reg   <= hold_full_next;
            parity_reg      <= parity_next;
            bit_cnt_reg     <= bit_cnt_next;
            stop_cnt_reg    <= stop_cnt_next;
            tx_reg          <= tx_next;
            baud_enable_reg <= baud_enable_next;
            frame_done_reg  <= frame_done_next;
        end
    end

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Testbench for uart_tx_sequencer.
// Three sequencers share clk/reset: u0 uses the defaults, u1 sends 7 data bits
// with even parity and 2 stop bits, and u2 uses odd parity. Each one has a
// behavioural baud generator with BAUDRATE=4 that parks one count before its
// tick while baud_enable is low. Expected frames are written out by hand as
// {stop, [parity], data, start} vectors, with bit 0 sent first.

module tb_uart_tx_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       rst_n;
    assign rst_n = !reset;

    logic [7:0] din0;
    logic [6:0] din1;
    logic [7:0] din2;
    logic       vld  [3];
    logic       rdy  [3];
    logic       tick [3];
    logic       ben  [3];
    logic       txs  [3];
    logic       bsy  [3];
    logic       fdn  [3];
    logic [1:0] bcnt [3];

    int checks = 0;
    int errors = 0;

    // Baud generator model, BAUDRATE=4, with registered tick output.
    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                bcnt[i] <= 2'd3;
                tick[i] <= 1'b0;
            end else if (!ben[i]) begin
                bcnt[i] <= 2'd3;
                tick[i] <= 1'b0;
            end else if (bcnt[i] == 2'd3) begin
                bcnt[i] <= 2'd0;
                tick[i] <= 1'b1;
            end else begin
                bcnt[i] <= bcnt[i] + 2'd1;
                tick[i] <= 1'b0;
            end
        end
    end

    uart_tx_sequencer u0 (
        .clk(clk), .reset(reset), .in_data(din0), .in_valid(vld[0]),
        .in_ready(rdy[0]), .clk_baud(tick[0]), .baud_enable(ben[0]),
        .tx(txs[0]), .busy(bsy[0]), .frame_done(fdn[0])
    );

    uart_tx_sequencer #(.DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(2)) u1 (
        .clk(clk), .reset(reset), .in_data(din1), .in_valid(vld[1]),
        .in_ready(rdy[1]), .clk_baud(tick[1]), .baud_enable(ben[1]),
        .tx(txs[1]), .busy(bsy[1]), .frame_done(fdn[1])
    );

    uart_tx_sequencer #(.PARITY_MODE(2)) u2 (
        .clk(clk), .reset(reset), .in_data(din2), .in_valid(vld[2]),
        .in_ready(rdy[2]), .clk_baud(tick[2]), .baud_enable(ben[2]),
        .tx(txs[2]), .busy(bsy[2]), .frame_done(fdn[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one word for exactly one edge; that edge is the accept edge N.
    task automatic send(input int inst, input logic [7:0] d);
        case (inst)
            0:       din0 = d;
            1:       din1 = d[6:0];
            default: din2 = d;
        endcase
        vld[inst] = 1'b1;
        step();
        vld[inst] = 1'b0;
    endtask

    // Called just after accept edge N. Checks tx, frame_done and busy after
    // every edge N+k: tx falls at N+2 and each bit lasts 4 cycles.
    task automatic check_frame(input int inst, input logic [31:0] frame,
                               input int len, input int flen, input string tag);
        int cycles;
        cycles = 2 + 4 * len;
        for (int k = 1; k <= cycles; k++) begin
            logic exp_tx;
            logic exp_fd;
            int   idx;
            step();
            idx = (k - 2) / 4;
            if (k < 2 || idx >= len) exp_tx = 1'b1;
            else                     exp_tx = frame[idx];
            exp_fd = (k > 2) && (((k - 2) % (4 * flen)) == 0);
            check($sformatf("%s tx k=%0d", tag, k), 32'(txs[inst]), 32'(exp_tx));
            check($sformatf("%s frame_done k=%0d", tag, k), 32'(fdn[inst]), 32'(exp_fd));
            check($sformatf("%s busy k=%0d", tag, k), 32'(bsy[inst]), 32'(k < cycles));
        end
        check($sformatf("%s baud_enable end", tag), 32'(ben[inst]), 32'd0);
        check($sformatf("%s busy end", tag), 32'(bsy[inst]), 32'd0);
        $display("frame %s: %0d bit periods on unit %0d", tag, len, inst);
    endtask

    initial begin
        int low_cnt;
        int ben_cnt;

        reset = 1'b1;
        din0  = '0;
        din1  = '0;
        din2  = '0;
        for (int i = 0; i < 3; i++) vld[i] = 1'b0;
        repeat (2) step();

        check("reset tx", 32'(txs[0]), 32'd1);
        check("reset baud_enable", 32'(ben[0]), 32'd0);
        check("reset in_ready", 32'(rdy[0]), 32'd1);
        check("reset busy", 32'(bsy[0]), 32'd0);
        check("reset frame_done", 32'(fdn[0]), 32'd0);
        #2 reset = 1'b0;
        step();

        // Single byte 0xA5.
        send(0, 8'hA5);
        check("a5 baud_enable after accept", 32'(ben[0]), 32'd1);
        check("a5 tx after accept", 32'(txs[0]), 32'd1);
        check_frame(0, 32'({1'b1, 8'hA5, 1'b0}), 10, 10, "a5");
        repeat (3) step();

        // Back-to-back: 0x55 at N, 0x0F at N+3 into the holding register.
        send(0, 8'h55);
        fork
            check_frame(0, 32'({1'b1, 8'h0F, 1'b0, 1'b1, 8'h55, 1'b0}), 20, 10, "b2b");
            begin
                step();
                step();
                check("b2b in_ready before second", 32'(rdy[0]), 32'd1);
                din0   = 8'h0F;
                vld[0] = 1'b1;
                step();
                vld[0] = 1'b0;
                check("b2b in_ready held", 32'(rdy[0]), 32'd0);
                repeat (38) step();
                check("b2b in_ready before move", 32'(rdy[0]), 32'd0);
                step();
                check("b2b in_ready after move", 32'(rdy[0]), 32'd1);
            end
        join
        repeat (3) step();

        // Word accepted on the very edge of the final stop tick.
        send(0, 8'hA5);
        fork
            check_frame(0, 32'({1'b1, 8'h3C, 1'b0, 1'b1, 8'hA5, 1'b0}), 20, 10, "bypass");
            begin
                repeat (41) step();
                din0   = 8'h3C;
                vld[0] = 1'b1;
                step();
                vld[0] = 1'b0;
            end
        join
        repeat (3) step();

        // Holding register full, in_valid held for 20 cycles with new data.
        send(0, 8'h81);
        fork
            check_frame(0, 32'({1'b1, 8'h42, 1'b0, 1'b1, 8'h81, 1'b0}), 20, 10, "stall");
            begin
                step();
                din0   = 8'h42;
                vld[0] = 1'b1;
                step();
                check("stall in_ready", 32'(rdy[0]), 32'd0);
                for (int i = 0; i < 19; i++) begin
                    din0 = 8'(8'hC0 + i);
                    step();
                end
                vld[0] = 1'b0;
            end
        join
        repeat (3) step();

        // Even parity, 7 data bits, 2 stops: 0x13 has three ones -> parity 1.
        send(1, 8'h13);
        check_frame(1, 32'({2'b11, 1'b1, 7'h13, 1'b0}), 11, 11, "even13");
        repeat (3) step();

        // Odd parity: 0x00 -> 1, 0x01 -> 0.
        send(2, 8'h00);
        check_frame(2, 32'({1'b1, 1'b1, 8'h00, 1'b0}), 11, 11, "odd00");
        repeat (3) step();
        send(2, 8'h01);
        check_frame(2, 32'({1'b1, 1'b0, 8'h01, 1'b0}), 11, 11, "odd01");
        repeat (3) step();

        // Reset in the middle of DATA with 0x99 buffered.
        send(0, 8'hC3);
        step();
        din0   = 8'h99;
        vld[0] = 1'b1;
        step();
        vld[0] = 1'b0;
        check("rst hold full", 32'(rdy[0]), 32'd0);
        repeat (12) step();
        check("rst tx before reset", 32'(txs[0]), 32'd0);
        #3 reset = 1'b1;
        #1;
        check("rst tx async", 32'(txs[0]), 32'd1);
        check("rst baud_enable async", 32'(ben[0]), 32'd0);
        check("rst busy async", 32'(bsy[0]), 32'd0);
        check("rst in_ready async", 32'(rdy[0]), 32'd1);
        step();
        step();
        #2 reset = 1'b0;
        step();
        check("rst in_ready after release", 32'(rdy[0]), 32'd1);
        low_cnt = 0;
        ben_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (txs[0] !== 1'b1) low_cnt++;
            if (ben[0] !== 1'b0) ben_cnt++;
        end
        check("rst discarded word tx low cycles", 32'(low_cnt), 32'd0);
        check("rst discarded word baud cycles", 32'(ben_cnt), 32'd0);
        $display("reset abort: line idle for 100 cycles after release");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_sequencer.md
Name: uart_tx_sequencer

Overview:
Controller that sequences the transmitter baud generator and serialises bytes onto the UART line. Accepts parallel words over a valid/ready handshake and buffers one word. Drives the generator's baud_enable and consumes its clk_baud tick to emit start, data (LSB first), optional parity and stop bits. Sits between the host-side byte source and the tx pin, alongside the transmitter baud generator.

Parameters:
DATA_BITS, 8, data bits per frame; legal range 5..8.
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd.
STOP_BITS, 1, stop bits per frame; 1 or 2.

Ports:
clk  input  1  system clock (50 MHz).
reset  input  1  asynchronous, active-high reset.
in_data  input  DATA_BITS  word to transmit.
in_valid  input  1  in_data is valid.
in_ready  output  1  holding register is empty; a transfer occurs on a clk edge where in_valid and in_ready are both high.
clk_baud  input  1  one-cycle tick from the baud generator.
baud_enable  output  1  enables the baud generator; low parks it one count before its tick.
tx  output  1  serial line; idle high.
busy  output  1  high whenever state is not IDLE.
frame_done  output  1  one-cycle pulse on the edge that ends the last stop bit.

Behaviour:
- Uses one clock. Reset is asynchronous and active-high. On reset: state=IDLE, tx=1, baud_enable=0, in_ready=1, busy=0, frame_done=0, holding register empty, bit counters=0.
- A reset mid-frame aborts the frame immediately. tx returns high asynchronously and any buffered word is discarded.
- All outputs are registered except in_ready (equals !hold_full) and busy.
- Storage: a shift register (active frame) and a one-entry holding register. in_ready=1 whenever the holding register is empty, including during a frame.
- Accept in IDLE: the word loads directly into the shift register. Next state is ARM and baud_enable<=1. The holding register stays empty.
- Accept while not in IDLE: the word goes to the holding register.
- State machine. Transitions occur only on clk edges where clk_baud=1, except IDLE->ARM.
  - ARM: tick -> tx<=0, go to START.
  - START: tick -> tx<=shift[0], bit_cnt<=1, go to DATA.
  - DATA: tick with bit_cnt<DATA_BITS -> tx<=shift[bit_cnt], bit_cnt++.
  - DATA: tick with bit_cnt==DATA_BITS -> tx<=parity, go to PARITY if PARITY_MODE!=0. Otherwise tx<=1, stop_cnt<=1, go to STOP.
  - PARITY: tick -> tx<=1, stop_cnt<=1, go to STOP.
  - STOP: tick with stop_cnt<STOP_BITS -> stop_cnt++ (tx stays 1).
  - STOP: tick with stop_cnt==STOP_BITS -> frame_done<=1. If the holding register is full, move it to the shift register, tx<=0, go to START (back-to-back, no idle gap, baud_enable stays 1). Otherwise baud_enable<=0 and go to IDLE.
- Parity is computed over the DATA_BITS bits of the frame being sent. Even: XOR of the bits. Odd: inverted XOR.
- Latency: accept at edge N gives baud_enable=1 after N. The generator ticks in cycle N+1, so tx falls at edge N+2. Every subsequent bit lasts exactly BAUDRATE cycles of the generator.
- Frame length = 1 + DATA_BITS + (PARITY_MODE!=0) + STOP_BITS bit periods.
- Simultaneous events:
  - Accept on the same edge as the final stop tick with the holding register empty: the new word is sent back-to-back. The holding path is bypassed straight into the shift register, with no IDLE and no gap.
  - in_valid held with the holding register full: stalled (in_ready=0), data not sampled.
- clk_baud while in IDLE is ignored.

Test Plan:
- Bench setup for all scenarios: the generator is instantiated with BAUDRATE=4 and its reset tied to !reset.
- Single byte 0xA5, defaults, accepted at edge N -> tx=0 from N+2 to N+6; data bits 1,0,1,0,0,1,0,1 at 4 cycles each; tx=1 from N+38; frame_done pulse and baud_enable=0 at edge N+42; busy=0 after.
- Back-to-back: 0x55 accepted at N, then 0x0F accepted at N+3 -> in_ready low from N+4 until the second word moves to the shift register. Second start bit begins at edge N+42 with no idle cycle. Total tx activity is 80 cycles.
- PARITY_MODE=1, DATA_BITS=7, STOP_BITS=2, word 0x13 -> parity bit=1 and two stop periods. frame_done comes 44 cycles after tx falls.
- PARITY_MODE=2, word 0x00 -> parity bit=1. With word 0x01 -> parity bit=0.
- Reset asserted mid-DATA with a word buffered -> tx=1 and baud_enable=0 immediately. After reset releases, in_ready=1 and the discarded word is never transmitted.
- Holding register full and in_valid held high for 20 cycles with changing data -> only the value present at the accept edge is transmitted.
